cmd_stream_loader: RTL and testbench
====================================

Name: cmd_stream_loader

Overview:
- Second-generation ioctl file loader for the TRS-80 core: parses TRS-80 /CMD record streams, or loads raw binaries to a fixed base, into system RAM.
- Sits between the HPS ioctl download interface and the RAM write port.
- Adds a RAM write handshake with ioctl backpressure, skipping of comment/unknown records, format errors, a byte counter and a deferred execute pulse.

Parameters:
- ADDR, 16, RAM address width (≥16).
- CMD_INDEX, 8'd2, lowest ioctl_index treated as /CMD; indices ≥ CMD_INDEX use CMD mode.
- RAW_INDEX, 8'd1, ioctl_index selecting raw binary mode.
- RAW_BASE, 16'h5200, load address for raw mode.
- RAW_EXEC, 1, raw mode issues execute at RAW_BASE on completion.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ioctl_download  in  1  download active.
- ioctl_index  in  8  menu index of file.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_dout  in  8  download byte.
- ioctl_wait  out  1  hold further bytes.
- loader_download  out  1  loader owns RAM.
- loader_wr  out  1  RAM write request, held until ram_ack.
- loader_addr  out  ADDR  RAM write address.
- loader_data  out  8  RAM write data.
- ram_ack  in  1  write accepted this cycle.
- execute_addr  out  ADDR  program entry address.
- execute_enable  out  1  one-cycle start pulse.
- loader_error  out  1  sticky error flag, cleared at next download start.
- error_code  out  2  0 none, 1 bad record type, 2 truncated, 3 no transfer record.
- bytes_written  out  17  RAM bytes written in this download.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE. Reset mid-transfer aborts immediately with no execute pulse.
- Start: a rising edge of ioctl_download in IDLE starts a download.
  - Mode is RAW if ioctl_index == RAW_INDEX, CMD if ioctl_index ≥ CMD_INDEX, otherwise the download is ignored.
  - On start: loader_download = 1, and error, error_code and bytes_written are cleared.
- Byte acceptance: bytes are accepted only on ioctl_wr while ioctl_wait = 0. ioctl_wr strobes are guaranteed ≥4 clocks apart.
- RAM handshake:
  - A data byte accepted in cycle N gives loader_wr = 1, loader_addr and loader_data valid, and ioctl_wait = 1 in cycle N+1.
  - These hold until the cycle ram_ack = 1. In the following cycle loader_wr = 0, ioctl_wait = 0, loader_addr increments (wraps modulo 2^ADDR) and bytes_written increments (saturates at 17'h1FFFF).
  - ram_ack while loader_wr = 0 is ignored.
- CMD state machine:
  - TYPE:
    - 8'h01 → LEN1.
    - 8'h02 → LEN2.
    - 8'h03..8'h1F → SKIPLEN.
    - 8'h00 or ≥ 8'h20 → ERR with code 1.
  - LEN1: data count N = len − 2, with len 0/1/2 giving 254/255/256. The count is held in a 9-bit counter. → ALO.
  - ALO, AHI: capture the address little-endian. → DATA, with loader_addr = captured address.
  - DATA: each accepted byte performs a write via the handshake and decrements N. When N reaches 0 after the final write's ack → TYPE.
  - LEN2 → XLO → XHI: capture execute_addr and set the xfer_seen flag. Then DRAIN: all remaining bytes are discarded.
  - SKIPLEN: latch len (0 means 256). SKIP discards len bytes, then → TYPE.
  - ERR: discard bytes until ioctl_download falls. Set loader_error = 1 and error_code.
- Download end: ioctl_download falling is detected in any state.
  - If a write is pending, completion waits for ram_ack first.
  - Truncation: end in LEN*, ALO, AHI, XLO, XHI, or DATA/SKIP with a nonzero count → error code 2, no execute.
  - End in TYPE or DRAIN with no error:
    - xfer_seen = 1 → execute_enable pulses 1 cycle.
    - Otherwise loader_error = 1 with code 3, and no execute.
  - In the completion cycle loader_download falls to 0 and the state returns to IDLE. The execute pulse occurs in the same cycle.
- RAW mode:
  - loader_addr = RAW_BASE at start. Every accepted byte is written via the handshake.
  - At end: if RAW_EXEC, execute_addr = RAW_BASE and execute_enable pulses. Zero-length raw files give no pulse.
- Simultaneous events:
  - ioctl_download falling in the same cycle as a final ioctl_wr: the byte is processed first.
  - ram_ack in the same cycle as the end of download: the write completes, then the end is processed the next cycle.
- A new rising edge of ioctl_download while not IDLE is ignored.

Test Plan:
- CMD 01 05 00 60 AA BB CC 02 02 00 60, ram_ack 2 cycles after each loader_wr → writes AA/BB/CC to 6000/6001/6002; bytes_written = 3; execute_addr = 6000; one execute_enable pulse at end; loader_error = 0.
- CMD 01 02 00 70 + 256 bytes, then 02 02 00 70 → 256 writes 7000..70FF; count wraps correctly through the 9-bit counter.
- CMD 05 03 41 42 43, then 01 03 10 80 5A, then 02 02 10 80 → comment skipped; single write 5A@8010; execute at 8010.
- CMD 01 06 00 60 11 22, then download ends → 2 writes; loader_error = 1, error_code = 2; no execute_enable.
- RAW index 1, bytes 01 02 03, ram_ack held low 10 cycles on the 2nd byte → ioctl_wait high throughout the stall; writes to 5200..5202; execute_addr = 5200 pulse.
- CMD first byte 8'h40 → error_code = 1; no writes; loader_download stays 1 until ioctl_download falls. Reset mid-DATA → all outputs 0 next cycle.

Source files
------------

// File: rtl/cmd_stream_loader.sv
// Loads TRS-80 /CMD record streams, or raw binaries at a fixed base, from the ioctl port into RAM.
// Each data byte becomes one RAM write. The write is held, with ioctl_wait high, until ram_ack arrives.
module cmd_stream_loader #(
  parameter int          ADDR      = 16,
  parameter logic [7:0]  CMD_INDEX = 8'd2,
  parameter logic [7:0]  RAW_INDEX = 8'd1,
  parameter logic [15:0] RAW_BASE  = 16'h5200,
  parameter bit          RAW_EXEC  = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ioctl_download,
  input  logic [7:0]      ioctl_index,
  input  logic            ioctl_wr,
  input  logic [7:0]      ioctl_dout,
  output logic            ioctl_wait,
  output logic            loader_download,
  output logic            loader_wr,
  output logic [ADDR-1:0] loader_addr,
  output logic [7:0]      loader_data,
  input  logic            ram_ack,
  output logic [ADDR-1:0] execute_addr,
  output logic            execute_enable,
  output logic            loader_error,
  output logic [1:0]      error_code,
  output logic [16:0]     bytes_written
);

  typedef enum logic [3:0] {
    S_IDLE, S_TYPE, S_LEN1, S_ALO, S_AHI, S_DATA, S_LEN2,
    S_XLO, S_XHI, S_DRAIN, S_SKIPLEN, S_SKIP, S_ERR, S_RAW
  } state_t;

  state_t          r_state;
  logic            r_dl_prev;
  logic            r_dl;
  logic            r_wr;
  logic [ADDR-1:0] r_addr;
  logic [7:0]      r_data;
  logic [ADDR-1:0] r_exec_addr;
  logic            r_exec_en;
  logic            r_err;
  logic [1:0]      r_code;
  logic [16:0]     r_bytes;
  logic [8:0]      r_cnt;
  logic [7:0]      r_lo;
  logic            r_xfer;

  logic            w_start;
  logic            w_acc;
  logic            w_end;
  logic [8:0]      w_len_n;
  logic [8:0]      w_skip_n;
  logic [ADDR-1:0] w_cap_addr;
  logic [ADDR-1:0] w_raw_base;

  assign w_start    = ioctl_download && !r_dl_prev;
  assign w_acc      = ioctl_wr && !r_wr;
  // A byte arriving with the falling edge is consumed first; the end is taken once nothing is pending.
  assign w_end      = (r_state != S_IDLE) && !ioctl_download && !r_wr && !ioctl_wr;
  // Load record length counts the two address bytes; 8-bit wrap gives 254/255 for len 0/1.
  assign w_len_n    = (ioctl_dout == 8'd2) ? 9'd256 : {1'b0, ioctl_dout - 8'd2};
  assign w_skip_n   = {(ioctl_dout == 8'd0), ioctl_dout};
  assign w_cap_addr = ADDR'({ioctl_dout, r_lo});
  assign w_raw_base = ADDR'(RAW_BASE);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_dl_prev   <= 1'b0;
      r_dl        <= 1'b0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_exec_addr <= '0;
      r_exec_en   <= 1'b0;
      r_err       <= 1'b0;
      r_code      <= 2'd0;
      r_bytes     <= '0;
      r_cnt       <= '0;
      r_lo        <= '0;
      r_xfer      <= 1'b0;
    end else begin
      r_dl_prev <= ioctl_download;
      r_exec_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start && (ioctl_index == RAW_INDEX || ioctl_index >= CMD_INDEX)) begin
            r_dl    <= 1'b1;
            r_err   <= 1'b0;
            r_code  <= 2'd0;
            r_bytes <= '0;
            r_xfer  <= 1'b0;
            if (ioctl_index == RAW_INDEX) begin
              r_state <= S_RAW;
              r_addr  <= w_raw_base;
            end else begin
              r_state <= S_TYPE;
            end
          end
        end
        default: begin
          if (r_wr) begin
            if (ram_ack) begin
              r_wr   <= 1'b0;
              r_addr <= r_addr + ADDR'(1);
              if (r_bytes != 17'h1FFFF)
                r_bytes <= r_bytes + 17'd1;
              if (r_state == S_DATA) begin
                r_cnt <= r_cnt - 9'd1;
                if (r_cnt == 9'd1)
                  r_state <= S_TYPE;
              end
            end
          end else if (w_end) begin
            r_state <= S_IDLE;
            r_dl    <= 1'b0;
            case (r_state)
              S_ERR: ;
              S_TYPE, S_DRAIN: begin
                if (r_xfer) begin
                  r_exec_en <= 1'b1;
                end else begin
                  r_err  <= 1'b1;
                  r_code <= 2'd3;
                end
              end
              S_RAW: begin
                if (RAW_EXEC && r_bytes != 17'd0) begin
                  r_exec_en   <= 1'b1;
                  r_exec_addr <= w_raw_base;
                end
              end
              default: begin
                r_err  <= 1'b1;
                r_code <= 2'd2;
              end
            endcase
          end else if (w_acc) begin
            case (r_state)
              S_TYPE: begin
                if (ioctl_dout == 8'h01) begin
                  r_state <= S_LEN1;
                end else if (ioctl_dout == 8'h02) begin
                  r_state <= S_LEN2;
                end else if (ioctl_dout >= 8'h03 && ioctl_dout <= 8'h1F) begin
                  r_state <= S_SKIPLEN;
                end else begin
                  r_state <= S_ERR;
                  r_err   <= 1'b1;
                  r_code  <= 2'd1;
                end
              end
              S_LEN1: begin
                r_cnt   <= w_len_n;
                r_state <= S_ALO;
              end
              S_ALO: begin
                r_lo    <= ioctl_dout;
                r_state <= S_AHI;
              end
              S_AHI: begin
                r_addr  <= w_cap_addr;
                r_state <= S_DATA;
              end
              S_DATA, S_RAW: begin
                r_wr   <= 1'b1;
                r_data <= ioctl_dout;
              end
              S_LEN2: r_state <= S_XLO;
              S_XLO: begin
                r_lo    <= ioctl_dout;
                r_state <= S_XHI;
              end
              S_XHI: begin
                r_exec_addr <= w_cap_addr;
                r_xfer      <= 1'b1;
                r_state     <= S_DRAIN;
              end
              S_SKIPLEN: begin
                r_cnt   <= w_skip_n;
                r_state <= S_SKIP;
              end
              S_SKIP: begin
                r_cnt <= r_cnt - 9'd1;
                if (r_cnt == 9'd1)
                  r_state <= S_TYPE;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign ioctl_wait      = r_wr;
  assign loader_download = r_dl;
  assign loader_wr       = r_wr;
  assign loader_addr     = r_addr;
  assign loader_data     = r_data;
  assign execute_addr    = r_exec_addr;
  assign execute_enable  = r_exec_en;
  assign loader_error    = r_err;
  assign error_code      = r_code;
  assign bytes_written   = r_bytes;

endmodule

// File: tb/tb_cmd_stream_loader.sv
// Directed bench for cmd_stream_loader: drives bytes on the falling edge and samples on the falling edge.
module tb_cmd_stream_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic        ioctl_wait;
  logic        loader_download;
  logic        loader_wr;
  logic [15:0] loader_addr;
  logic [7:0]  loader_data;
  logic        ram_ack = 1'b0;
  logic [15:0] execute_addr;
  logic        execute_enable;
  logic        loader_error;
  logic [1:0]  error_code;
  logic [16:0] bytes_written;

  int vectors = 0;
  int miscompares = 0;
  int exec_cnt = 0;

  cmd_stream_loader dut (
    .clock           (clock),
    .reset           (reset),
    .ioctl_download  (ioctl_download),
    .ioctl_index     (ioctl_index),
    .ioctl_wr        (ioctl_wr),
    .ioctl_dout      (ioctl_dout),
    .ioctl_wait      (ioctl_wait),
    .loader_download (loader_download),
    .loader_wr       (loader_wr),
    .loader_addr     (loader_addr),
    .loader_data     (loader_data),
    .ram_ack         (ram_ack),
    .execute_addr    (execute_addr),
    .execute_enable  (execute_enable),
    .loader_error    (loader_error),
    .error_code      (error_code),
    .bytes_written   (bytes_written)
  );

  always #5 clock = ~clock;

  always @(posedge clock)
    if (execute_enable === 1'b1) exec_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {ioctl_wait, loader_download, loader_wr, loader_addr, loader_data,
                execute_addr, execute_enable, loader_error, error_code, bytes_written}, 64'd0);
  endtask

  task automatic start_dl(input logic [7:0] idx);
    @(negedge clock);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    @(negedge clock);
    check("start_dl", loader_download, 1'b1);
    check("start_err_clr", {loader_error, error_code}, 3'd0);
    check("start_bytes_clr", bytes_written, 17'd0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    ioctl_wr = 1'b1;
    ioctl_dout = b;
    @(negedge clock);
    ioctl_wr = 1'b0;
    check("nodata_no_wr", {loader_wr, ioctl_wait}, 2'b00);
    repeat (3) @(negedge clock);
  endtask

  task automatic send_data(input logic [7:0] b, input logic [15:0] a, input int d);
    @(negedge clock);
    ioctl_wr = 1'b1;
    ioctl_dout = b;
    @(negedge clock);
    ioctl_wr = 1'b0;
    check("data_wr", {loader_wr, ioctl_wait}, 2'b11);
    check("data_addr", loader_addr, a);
    check("data_byte", loader_data, b);
    for (int i = 1; i < d; i++) begin
      @(negedge clock);
      check("stall_hold", {loader_wr, ioctl_wait, loader_addr}, {2'b11, a});
    end
    ram_ack = 1'b1;
    @(negedge clock);
    ram_ack = 1'b0;
    check("ack_release", {loader_wr, ioctl_wait}, 2'b00);
    check("ack_addr_inc", loader_addr, a + 16'd1);
    repeat (2) @(negedge clock);
  endtask

  task automatic end_dl(input logic exp_exec, input logic exp_err, input logic [1:0] exp_code);
    int  c0;
    bit  seen;
    c0 = exec_cnt;
    seen = 1'b0;
    @(negedge clock);
    ioctl_download = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (loader_download === 1'b0) seen = 1'b1;
    end
    check("end_dl_fell", loader_download, 1'b0);
    check("end_exec_pulse", execute_enable, exp_exec);
    check("end_err", {loader_error, error_code}, {exp_err, exp_code});
    @(negedge clock);
    check("exec_single", execute_enable, 1'b0);
    @(negedge clock);
    check("exec_count", exec_cnt - c0, exp_exec);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check_all_zero("reset_outs");
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // 1: short load record then transfer record
    start_dl(8'd2);
    send_byte(8'h01); send_byte(8'h05); send_byte(8'h00); send_byte(8'h60);
    send_data(8'hAA, 16'h6000, 2);
    send_data(8'hBB, 16'h6001, 2);
    send_data(8'hCC, 16'h6002, 2);
    send_byte(8'h02); send_byte(8'h02); send_byte(8'h00); send_byte(8'h60);
    check("t1_bytes", bytes_written, 17'd3);
    end_dl(1'b1, 1'b0, 2'd0);
    check("t1_exec_addr", execute_addr, 16'h6000);

    // 2: len 2 encodes 256 data bytes
    start_dl(8'd2);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h00); send_byte(8'h70);
    for (int i = 0; i < 256; i++)
      send_data(8'(i), 16'h7000 + 16'(i), 1);
    check("t2_bytes", bytes_written, 17'd256);
    send_byte(8'h02); send_byte(8'h02); send_byte(8'h00); send_byte(8'h70);
    end_dl(1'b1, 1'b0, 2'd0);
    check("t2_exec_addr", execute_addr, 16'h7000);

    // 3: comment record skipped, then a one-byte load
    start_dl(8'd3);
    send_byte(8'h05); send_byte(8'h03);
    send_byte(8'h41); send_byte(8'h42); send_byte(8'h43);
    send_byte(8'h01); send_byte(8'h03); send_byte(8'h10); send_byte(8'h80);
    send_data(8'h5A, 16'h8010, 3);
    send_byte(8'h02); send_byte(8'h02); send_byte(8'h10); send_byte(8'h80);
    check("t3_bytes", bytes_written, 17'd1);
    end_dl(1'b1, 1'b0, 2'd0);
    check("t3_exec_addr", execute_addr, 16'h8010);

    // 4: truncated inside a data record
    start_dl(8'd2);
    send_byte(8'h01); send_byte(8'h06); send_byte(8'h00); send_byte(8'h60);
    send_data(8'h11, 16'h6000, 2);
    send_data(8'h22, 16'h6001, 2);
    end_dl(1'b0, 1'b1, 2'd2);
    check("t4_bytes", bytes_written, 17'd2);
    check("t4_exec_addr_kept", execute_addr, 16'h8010);

    // 5: complete records but no transfer record
    start_dl(8'd2);
    send_byte(8'h01); send_byte(8'h03); send_byte(8'h00); send_byte(8'h90);
    send_data(8'h77, 16'h9000, 1);
    end_dl(1'b0, 1'b1, 2'd3);

    // 6: raw mode with a long stall on the second byte
    start_dl(8'd1);
    check("t6_raw_base", loader_addr, 16'h5200);
    send_data(8'h01, 16'h5200, 1);
    send_data(8'h02, 16'h5201, 10);
    send_data(8'h03, 16'h5202, 1);
    check("t6_bytes", bytes_written, 17'd3);
    end_dl(1'b1, 1'b0, 2'd0);
    check("t6_exec_addr", execute_addr, 16'h5200);

    // 7: zero-length raw file gives no execute
    start_dl(8'd1);
    end_dl(1'b0, 1'b0, 2'd0);

    // 8: bad record type
    start_dl(8'd2);
    send_byte(8'h40);
    check("t8_err", {loader_error, error_code}, 3'b101);
    send_byte(8'h01); send_byte(8'h05);
    check("t8_dl_held", loader_download, 1'b1);
    check("t8_no_writes", bytes_written, 17'd0);
    end_dl(1'b0, 1'b1, 2'd1);

    // 9: index 0 is ignored
    @(negedge clock);
    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    repeat (2) @(negedge clock);
    check("t9_ignored", loader_download, 1'b0);
    ioctl_download = 1'b0;
    repeat (2) @(negedge clock);

    // 10: reset with a write pending inside a data record
    start_dl(8'd2);
    send_byte(8'h01); send_byte(8'h05); send_byte(8'h00); send_byte(8'h60);
    send_data(8'hAA, 16'h6000, 1);
    @(negedge clock);
    ioctl_wr = 1'b1;
    ioctl_dout = 8'hBB;
    @(negedge clock);
    ioctl_wr = 1'b0;
    check("t10_pending", loader_wr, 1'b1);
    reset = 1'b1;
    ioctl_download = 1'b0;
    @(negedge clock);
    check_all_zero("t10_reset_outs");
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("t10_no_exec", execute_enable, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
